// File: rtl/score_tracker_if.sv
// ============================================================================
// score_tracker_if : game-event inputs and score/state outputs of score_tracker
// Rev 1.0
// ============================================================================
`default_nettype none

interface score_tracker_if;
  logic        start;
  logic        point;
  logic [3:0]  points;
  logic        hit;
  logic [15:0] curr_score;
  logic [15:0] high_score;
  logic        death;
  logic        playing;
  logic        new_high;

  modport master (
    output start, point, points, hit,
    input  curr_score, high_score, death, playing, new_high
  );

  modport slave (
    input  start, point, points, hit,
    output curr_score, high_score, death, playing, new_high
  );
endinterface

`default_nettype wire

// File: rtl/score_tracker.sv
// ============================================================================
// score_tracker : game sequencing, saturating score, high score and restart lockout
// Rev 1.0
// ============================================================================
`default_nettype none

module score_tracker #(
  parameter int MAX_SCORE   = 9999,
  parameter int LOCK_CYCLES = 100000000,
  parameter int LOCK_W      = $clog2(LOCK_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  score_tracker_if.slave bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PLAYING = 2'd1;
  localparam logic [1:0] ST_DEAD    = 2'd2;

  localparam logic [16:0]       C_MAX17    = 17'(MAX_SCORE);
  localparam logic [LOCK_W-1:0] C_LOCK_MAX = LOCK_W'(LOCK_CYCLES);

  logic [1:0]        state_q, state_d;
  logic [15:0]       score_q, score_d;
  logic [15:0]       high_q, high_d;
  logic              death_q, death_d;
  logic              playing_q, playing_d;
  logic              new_high_q, new_high_d;
  logic [LOCK_W-1:0] lock_q, lock_d;

  logic [16:0] sum_w;
  logic [15:0] sat_w;
  logic [15:0] final_w;

  // Sum kept at 17 bits so saturation is decided before any truncation.
  assign sum_w   = {1'b0, score_q} + {13'd0, bus.points};
  assign sat_w   = (sum_w > C_MAX17) ? C_MAX17[15:0] : sum_w[15:0];
  assign final_w = bus.point ? sat_w : score_q;

  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    high_d     = high_q;
    death_d    = death_q;
    playing_d  = playing_q;
    new_high_d = new_high_q;
    lock_d     = lock_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_PLAYING;
          score_d   = 16'd0;
          playing_d = 1'b1;
        end
      end
      ST_PLAYING: begin
        score_d = final_w;
        if (bus.hit) begin
          state_d    = ST_DEAD;
          death_d    = 1'b1;
          playing_d  = 1'b0;
          lock_d     = '0;
          new_high_d = (final_w > high_q);
          if (final_w > high_q) begin
            high_d = final_w;
          end
        end
      end
      ST_DEAD: begin
        if (lock_q != C_LOCK_MAX) begin
          lock_d = lock_q + LOCK_W'(1);
        end
        if (bus.start && (lock_q == C_LOCK_MAX)) begin
          state_d    = ST_PLAYING;
          score_d    = 16'd0;
          death_d    = 1'b0;
          new_high_d = 1'b0;
          playing_d  = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        death_d   = 1'b0;
        playing_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      score_q    <= 16'd0;
      high_q     <= 16'd0;
      death_q    <= 1'b0;
      playing_q  <= 1'b0;
      new_high_q <= 1'b0;
      lock_q     <= '0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      high_q     <= high_d;
      death_q    <= death_d;
      playing_q  <= playing_d;
      new_high_q <= new_high_d;
      lock_q     <= lock_d;
    end
  end

  assign bus.curr_score = score_q;
  assign bus.high_score = high_q;
  assign bus.death      = death_q;
  assign bus.playing    = playing_q;
  assign bus.new_high   = new_high_q;

endmodule

`default_nettype wire

// File: tb/tb_score_tracker.sv
// ============================================================================
// tb_score_tracker : directed plus randomized checks of score_tracker against a game model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_score_tracker;

  localparam int LOCK = 8;
  localparam int MAXS = 9999;

  logic clk;
  logic rst_n;
  score_tracker_if bus ();

  score_tracker #(.MAX_SCORE(MAXS), .LOCK_CYCLES(LOCK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Game model: 0 = idle, 1 = playing, 2 = dead; m_dead counts DEAD cycles already sampled.
  int m_mode  = 0;
  int m_score = 0;
  int m_high  = 0;
  int m_nh    = 0;
  int m_dead  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_score = 0; m_high = 0; m_nh = 0; m_dead = 0;
  endtask

  task automatic step(input logic s, input logic p, input logic [3:0] pts, input logic h);
    @(negedge clk);
    bus.start = s; bus.point = p; bus.points = pts; bus.hit = h;
    @(posedge clk);
    case (m_mode)
      0: if (s) begin m_mode = 1; m_score = 0; end
      1: begin
        if (p) m_score = (m_score + int'(pts) > MAXS) ? MAXS : m_score + int'(pts);
        if (h) begin
          m_mode = 2;
          m_dead = 0;
          m_nh   = (m_score > m_high) ? 1 : 0;
          if (m_score > m_high) m_high = m_score;
        end
      end
      default: begin
        if (s && m_dead >= LOCK) begin
          m_mode = 1; m_score = 0; m_nh = 0;
        end else begin
          m_dead++;
        end
      end
    endcase
    #1;
    bus.start = 1'b0; bus.point = 1'b0; bus.points = 4'd0; bus.hit = 1'b0;
  endtask

  task automatic restart();
    while (m_dead < LOCK) step(1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 4'd0, 1'b0);
  endtask

  always @(negedge clk) begin
    chk("curr_score", int'(bus.curr_score), m_score);
    chk("high_score", int'(bus.high_score), m_high);
    chk("death",      int'(bus.death),      (m_mode == 2) ? 1 : 0);
    chk("playing",    int'(bus.playing),    (m_mode == 1) ? 1 : 0);
    chk("new_high",   int'(bus.new_high),   (m_mode == 2) ? m_nh : 0);
  end

  initial begin
    bus.start = 1'b0; bus.point = 1'b0; bus.points = 4'd0; bus.hit = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst curr_score", int'(bus.curr_score), 0);
    chk("rst high_score", int'(bus.high_score), 0);
    chk("rst death",      int'(bus.death), 0);
    chk("rst playing",    int'(bus.playing), 0);
    chk("rst new_high",   int'(bus.new_high), 0);
    rst_n = 1'b1;

    step(1'b1, 1'b0, 4'd0, 1'b0);
    chk("start playing", int'(bus.playing), 1);
    repeat (3) step(1'b0, 1'b1, 4'd5, 1'b0);
    chk("3x5 score", int'(bus.curr_score), 15);
    chk("3x5 death", int'(bus.death), 0);

    step(1'b0, 1'b0, 4'd0, 1'b1);
    chk("hit death",    int'(bus.death), 1);
    chk("hit playing",  int'(bus.playing), 0);
    chk("hit high",     int'(bus.high_score), 15);
    chk("hit new_high", int'(bus.new_high), 1);
    step(1'b0, 1'b1, 4'd9, 1'b0);
    chk("dead point ignored", int'(bus.curr_score), 15);

    step(1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 4'd0, 1'b0);
    chk("early start ignored", int'(bus.death), 1);
    while (m_dead < LOCK - 1) step(1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 4'd0, 1'b0);
    chk("start one short ignored", int'(bus.death), 1);
    step(1'b1, 1'b0, 4'd0, 1'b0);
    chk("restart playing",  int'(bus.playing), 1);
    chk("restart death",    int'(bus.death), 0);
    chk("restart score",    int'(bus.curr_score), 0);
    chk("restart high",     int'(bus.high_score), 15);
    chk("restart new_high", int'(bus.new_high), 0);

    step(1'b0, 1'b1, 4'd10, 1'b0);
    step(1'b0, 1'b1, 4'd7, 1'b1);
    chk("point+hit score",    int'(bus.curr_score), 17);
    chk("point+hit high",     int'(bus.high_score), 17);
    chk("point+hit new_high", int'(bus.new_high), 1);

    restart();
    step(1'b0, 1'b1, 4'd10, 1'b0);
    step(1'b0, 1'b1, 4'd7, 1'b0);
    step(1'b0, 1'b0, 4'd0, 1'b1);
    chk("tie high",     int'(bus.high_score), 17);
    chk("tie new_high", int'(bus.new_high), 0);

    restart();
    step(1'b0, 1'b1, 4'd4, 1'b1);
    chk("low run score", int'(bus.curr_score), 4);
    chk("low run high",  int'(bus.high_score), 17);

    restart();
    repeat (666) step(1'b0, 1'b1, 4'd15, 1'b0);
    step(1'b0, 1'b1, 4'd5, 1'b0);
    chk("score 9995", int'(bus.curr_score), 9995);
    step(1'b0, 1'b1, 4'd15, 1'b0);
    chk("saturate 9999", int'(bus.curr_score), 9999);
    step(1'b0, 1'b1, 4'd1, 1'b0);
    chk("hold 9999", int'(bus.curr_score), 9999);
    step(1'b0, 1'b0, 4'd0, 1'b1);
    chk("max high", int'(bus.high_score), 9999);

    restart();
    step(1'b0, 1'b1, 4'd15, 1'b0);
    step(1'b0, 1'b1, 4'd15, 1'b0);
    step(1'b0, 1'b1, 4'd12, 1'b0);
    chk("score 42", int'(bus.curr_score), 42);
    #2 rst_n = 1'b0;
    #1;
    chk("async curr_score", int'(bus.curr_score), 0);
    chk("async high_score", int'(bus.high_score), 0);
    chk("async playing",    int'(bus.playing), 0);
    chk("async death",      int'(bus.death), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 4'd5, 1'b1);
    chk("idle ignores score", int'(bus.curr_score), 0);
    chk("idle ignores hit",   int'(bus.death), 0);
    step(1'b1, 1'b0, 4'd0, 1'b0);
    chk("idle start", int'(bus.playing), 1);

    for (int i = 0; i < 4000; i++) begin
      step(($urandom % 5) == 0, ($urandom % 3) == 0, 4'($urandom % 16), ($urandom % 40) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
